pad_dilate_layer: RTL and testbench

Streaming zero-padding and zero-insertion (dilation) stage for the generator's transposed-convolution path. It takes a channel-interleaved raster feature map and emits the padded, optionally stride-dilated map one word per cycle over valid/ready. Zero words are generated internally. It sits between an upstream layer output and the next convolution's line buffer. With `STRIDE=1` it behaves as a plain multi-channel padder with a fully registered, stall-safe output.

---
 rtl/pad_dilate_layer_if.sv | 19 +
 rtl/pad_dilate_layer.sv | 148 ++++++++++++++
 tb/tb_pad_dilate_layer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pad_dilate_layer_if.sv
// Valid/ready word stream used on both sides of pad_dilate_layer.
// Carries end-of-row/end-of-frame markers only when PDL_MARKERS_EN is defined.
interface pad_dilate_layer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         valid;
  logic signed [DATA_WIDTH-1:0] data;
  logic                         ready;
`ifdef PDL_MARKERS_EN
  logic                         eol;
  logic                         eof;

  modport master (output valid, output data, output eol, output eof, input ready);
  modport slave  (input valid, input data, input eol, input eof, output ready);
`else
  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
`endif
endinterface

// File: rtl/pad_dilate_layer.sv
// Streaming zero-padding / zero-insertion stage; emits one word per cycle over valid/ready.
// Optional PDL_MARKERS_EN adds registered end-of-row / end-of-frame markers.
module pad_dilate_layer #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 1,
  parameter int IMG_W      = 12,
  parameter int IMG_H      = 12,
  parameter int PAD_TOP    = 2,
  parameter int PAD_BOTTOM = 2,
  parameter int PAD_LEFT   = 2,
  parameter int PAD_RIGHT  = 2,
  parameter int STRIDE     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  pad_dilate_layer_if.slave    in_bus,
  pad_dilate_layer_if.master   out_bus
);

  localparam int DW    = (IMG_W - 1) * STRIDE + 1;
  localparam int DH    = (IMG_H - 1) * STRIDE + 1;
  localparam int OUT_W = PAD_LEFT + DW + PAD_RIGHT;
  localparam int OUT_H = PAD_TOP + DH + PAD_BOTTOM;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int OX_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int OY_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int PH_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  logic [CH_W-1:0]              ch_r;
  logic [OX_W-1:0]              ox_r;
  logic [OY_W-1:0]              oy_r;
  logic [PH_W-1:0]              px_r;
  logic [PH_W-1:0]              py_r;
  logic                         valid_r;
  logic signed [DATA_WIDTH-1:0] data_r;

  logic            last_ch_s;
  logic            last_x_s;
  logic            last_y_s;
  logic            x_in_s;
  logic            y_in_s;
  logic            data_pos_s;
  logic            adv_s;
  logic            load_s;
  logic            ready_in_s;
  logic [PH_W-1:0] px_next_s;
  logic [PH_W-1:0] py_next_s;

  // Position decode, handshake and phase successors (phase restarts at the first data column/row).
  always_comb begin
    last_ch_s  = (ch_r == CH_W'(CHANNELS - 1));
    last_x_s   = (ox_r == OX_W'(OUT_W - 1));
    last_y_s   = (oy_r == OY_W'(OUT_H - 1));
    x_in_s     = (int'(ox_r) >= PAD_LEFT) && (int'(ox_r) < PAD_LEFT + DW);
    y_in_s     = (int'(oy_r) >= PAD_TOP) && (int'(oy_r) < PAD_TOP + DH);
    data_pos_s = x_in_s && y_in_s && (px_r == {PH_W{1'b0}}) && (py_r == {PH_W{1'b0}});
    adv_s      = !valid_r || out_bus.ready;
    if (data_pos_s) begin
      ready_in_s = adv_s;
      load_s     = adv_s && in_bus.valid;
    end else begin
      ready_in_s = 1'b0;
      load_s     = adv_s;
    end
    if (!x_in_s) begin
      px_next_s = {PH_W{1'b0}};
    end else if (px_r == PH_W'(STRIDE - 1)) begin
      px_next_s = {PH_W{1'b0}};
    end else begin
      px_next_s = px_r + PH_W'(1);
    end
    if (!y_in_s) begin
      py_next_s = {PH_W{1'b0}};
    end else if (py_r == PH_W'(STRIDE - 1)) begin
      py_next_s = {PH_W{1'b0}};
    end else begin
      py_next_s = py_r + PH_W'(1);
    end
  end

  // Position and phase counters: step once per loaded word, ch fastest then ox then oy.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_r <= {CH_W{1'b0}};
      ox_r <= {OX_W{1'b0}};
      oy_r <= {OY_W{1'b0}};
      px_r <= {PH_W{1'b0}};
      py_r <= {PH_W{1'b0}};
    end else if (load_s) begin
      if (!last_ch_s) begin
        ch_r <= ch_r + CH_W'(1);
      end else begin
        ch_r <= {CH_W{1'b0}};
        if (!last_x_s) begin
          ox_r <= ox_r + OX_W'(1);
          px_r <= px_next_s;
        end else begin
          ox_r <= {OX_W{1'b0}};
          px_r <= {PH_W{1'b0}};
          if (!last_y_s) begin
            oy_r <= oy_r + OY_W'(1);
            py_r <= py_next_s;
          end else begin
            oy_r <= {OY_W{1'b0}};
            py_r <= {PH_W{1'b0}};
          end
        end
      end
    end
  end

  // Output register: data/valid only change when the downstream slot is free.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= {DATA_WIDTH{1'b0}};
    end else if (adv_s) begin
      valid_r <= load_s;
      if (load_s) begin
        data_r <= data_pos_s ? in_bus.data : {DATA_WIDTH{1'b0}};
      end
    end
  end

  assign out_bus.valid = valid_r;
  assign out_bus.data  = data_r;
  assign in_bus.ready  = ready_in_s;

`ifdef PDL_MARKERS_EN
  logic eol_r;
  logic eof_r;

  // Markers follow the loaded word and clear with valid when nothing is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      eol_r <= 1'b0;
      eof_r <= 1'b0;
    end else if (adv_s) begin
      eol_r <= load_s && last_ch_s && last_x_s;
      eof_r <= load_s && last_ch_s && last_x_s && last_y_s;
    end
  end

  assign out_bus.eol = eol_r;
  assign out_bus.eof = eof_r;
`endif

endmodule

// File: tb/tb_pad_dilate_layer.sv
// Scoreboard bench for pad_dilate_layer: three configurations (padding, dilation, channels),
// backpressure, mid-frame reset and, with PDL_MARKERS_EN, row/frame markers.
module tb_pad_dilate_layer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        vin  [3];
  logic [15:0] din  [3];
  logic        rout [3];
  logic        vout [3];
  logic [15:0] dout [3];
  logic        rin  [3];
`ifdef PDL_MARKERS_EN
  logic        eolo [3];
  logic        eofo [3];
`endif

  pad_dilate_layer_if #(.DATA_WIDTH(16)) a_in (), a_out (), b_in (), b_out (), c_in (), c_out ();

  assign a_in.valid = vin[0];  assign a_in.data = din[0];  assign a_out.ready = rout[0];
  assign b_in.valid = vin[1];  assign b_in.data = din[1];  assign b_out.ready = rout[1];
  assign c_in.valid = vin[2];  assign c_in.data = din[2];  assign c_out.ready = rout[2];
  assign vout[0] = a_out.valid; assign dout[0] = a_out.data; assign rin[0] = a_in.ready;
  assign vout[1] = b_out.valid; assign dout[1] = b_out.data; assign rin[1] = b_in.ready;
  assign vout[2] = c_out.valid; assign dout[2] = c_out.data; assign rin[2] = c_in.ready;
`ifdef PDL_MARKERS_EN
  assign a_in.eol = 1'b0; assign a_in.eof = 1'b0;
  assign b_in.eol = 1'b0; assign b_in.eof = 1'b0;
  assign c_in.eol = 1'b0; assign c_in.eof = 1'b0;
  assign eolo[0] = a_out.eol; assign eofo[0] = a_out.eof;
  assign eolo[1] = b_out.eol; assign eofo[1] = b_out.eof;
  assign eolo[2] = c_out.eol; assign eofo[2] = c_out.eof;
`endif

  pad_dilate_layer #(.DATA_WIDTH(16), .CHANNELS(1), .IMG_W(2), .IMG_H(2), .PAD_TOP(1), .PAD_BOTTOM(1),
                     .PAD_LEFT(1), .PAD_RIGHT(1), .STRIDE(1))
    dut_a (.clk(clk), .rst(rst), .in_bus(a_in), .out_bus(a_out));
  pad_dilate_layer #(.DATA_WIDTH(16), .CHANNELS(1), .IMG_W(2), .IMG_H(2), .PAD_TOP(0), .PAD_BOTTOM(0),
                     .PAD_LEFT(0), .PAD_RIGHT(0), .STRIDE(2))
    dut_b (.clk(clk), .rst(rst), .in_bus(b_in), .out_bus(b_out));
  pad_dilate_layer #(.DATA_WIDTH(16), .CHANNELS(2), .IMG_W(1), .IMG_H(1), .PAD_TOP(1), .PAD_BOTTOM(1),
                     .PAD_LEFT(1), .PAD_RIGHT(1), .STRIDE(1))
    dut_c (.clk(clk), .rst(rst), .in_bus(c_in), .out_bus(c_out));

  int          checks   = 0;
  int          failures = 0;
  int          sel      = 0;
  int          ocnt     = 0;
  int          rdy_cnt  = 0;
  bit          st_pend  = 1'b0;
  logic [15:0] st_data  = 16'h0000;
  logic [15:0] exp_q [$];
  logic [15:0] in_q  [$];
  bit          eol_q [$];
  bit          eof_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] in_word(input int d, input int k);
    if (d == 2) return (k == 0) ? 16'h0007 : 16'hFFF8;
    return 16'(k + 1);
  endfunction

  // Reference model: builds one frame of expected words/markers and the input words it consumes.
  task automatic push_frame(input int d);
    int c, w, h, p, s, dw, dh, ow, oh, rx, ry, idx;
    c = (d == 2) ? 2 : 1;
    w = (d == 2) ? 1 : 2;
    h = w;
    p = (d == 1) ? 0 : 1;
    s = (d == 1) ? 2 : 1;
    dw = (w - 1) * s + 1;
    dh = (h - 1) * s + 1;
    ow = dw + 2 * p;
    oh = dh + 2 * p;
    for (int k = 0; k < w * h * c; k++) in_q.push_back(in_word(d, k));
    for (int y = 0; y < oh; y++)
      for (int x = 0; x < ow; x++)
        for (int ch = 0; ch < c; ch++) begin
          rx = x - p;
          ry = y - p;
          if (rx >= 0 && rx < dw && ry >= 0 && ry < dh && rx % s == 0 && ry % s == 0) begin
            idx = ((ry / s) * w + rx / s) * c + ch;
            exp_q.push_back(in_word(d, idx));
          end else begin
            exp_q.push_back(16'h0000);
          end
          eol_q.push_back(ch == c - 1 && x == ow - 1);
          eof_q.push_back(ch == c - 1 && x == ow - 1 && y == oh - 1);
        end
  endtask

  // One negedge: verify stall hold, drive handshake, score any word taken at the next posedge.
  task automatic cycle(input bit rnd);
    @(negedge clk);
    if (st_pend) begin
      check("stall_valid", 32'(vout[sel]), 32'd1);
      check("stall_data", 32'(dout[sel]), 32'(st_data));
    end
    rout[sel] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    if (in_q.size() > 0) begin
      vin[sel] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      din[sel] = in_q[0];
    end else begin
      vin[sel] = 1'b0;
    end
    #1;
    if (vin[sel] && rin[sel]) void'(in_q.pop_front());
    if (rin[sel]) rdy_cnt++;
    st_pend = vout[sel] && !rout[sel];
    st_data = dout[sel];
    if (vout[sel] && rout[sel]) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'd1, 32'd0);
      end else begin
        check("data", 32'(dout[sel]), 32'(exp_q.pop_front()));
`ifdef PDL_MARKERS_EN
        check("eol", 32'(eolo[sel]), 32'(eol_q[0]));
        check("eof", 32'(eofo[sel]), 32'(eof_q[0]));
`endif
        void'(eol_q.pop_front());
        void'(eof_q.pop_front());
      end
      ocnt++;
    end
  endtask

  task automatic drain(input bit rnd);
    int budget = 2000;
    while (exp_q.size() > 0 && budget > 0) begin
      cycle(rnd);
      budget--;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rout[sel] = 1'b0;
    vin[sel]  = 1'b0;
  endtask

  // One-cycle reset with reset-value checks on every instance.
  task automatic rst_pulse();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin rout[i] = 1'b0; vin[i] = 1'b0; end
    st_pend = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_valid%0d", i), 32'(vout[i]), 32'd0);
      check($sformatf("rst_data%0d", i), 32'(dout[i]), 32'd0);
      check($sformatf("rst_ready_in%0d", i), 32'(rin[i]), (i == 1) ? 32'd1 : 32'd0);
`ifdef PDL_MARKERS_EN
      check($sformatf("rst_eol%0d", i), 32'(eolo[i]), 32'd0);
      check($sformatf("rst_eof%0d", i), 32'(eofo[i]), 32'd0);
`endif
    end
    rst = 1'b0;
    exp_q.delete(); in_q.delete(); eol_q.delete(); eof_q.delete();
    ocnt = 0;
    rdy_cnt = 0;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin vin[i] = 1'b0; din[i] = 16'h0000; rout[i] = 1'b0; end
    repeat (2) @(negedge clk);
    rst_pulse();

    // Plain padding: 16 back-to-back valid words, then the next frame follows immediately.
    sel = 0;
    push_frame(0);
    push_frame(0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0);
      check("consec_valid", 32'(vout[0]), 32'd1);
    end

    // Backpressure and input gaps over the remainder plus two more frames.
    push_frame(0);
    push_frame(0);
    drain(1'b1);

    // Mid-frame reset after the 6th output word.
    rst_pulse();
    push_frame(0);
    while (ocnt < 6) cycle(1'b0);
    rst_pulse();
    push_frame(0);
    drain(1'b0);

    // Dilation: ready_in high only on the four data positions.
    rst_pulse();
    sel = 1;
    push_frame(1);
    for (int i = 0; i < 9; i++) cycle(1'b0);
    check("dil_ready_cnt", 32'(rdy_cnt), 32'd4);
    drain(1'b0);

    // Two channels, single pixel.
    rst_pulse();
    sel = 2;
    push_frame(2);
    drain(1'b0);
    check("ch_word_cnt", 32'(ocnt), 32'd18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
